// File: rtl/mem_stage_if.sv
// Handshake and data buses around the memory-access stage: ES->MS input,
// data-SRAM response, MS->WS output and the MS->DS forwarding bus.
interface mem_stage_if;
    logic        es_to_ms_valid;
    logic [74:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        ws_allowin;
    logic [39:0] ms_to_ds_fwd;

    modport master (
        input  es_to_ms_valid,
        input  es_to_ms_bus,
        input  data_sram_data_ok,
        input  data_sram_rdata,
        input  ws_allowin,
        output ms_allowin,
        output ms_to_ws_valid,
        output ms_to_ws_bus,
        output ms_to_ds_fwd
    );

    modport slave (
        output es_to_ms_valid,
        output es_to_ms_bus,
        output data_sram_data_ok,
        output data_sram_rdata,
        output ws_allowin,
        input  ms_allowin,
        input  ms_to_ws_valid,
        input  ms_to_ws_bus,
        input  ms_to_ds_fwd
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for the data-SRAM
// response, extracts/extends load data and drives the writeback and forwarding buses.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.master bus
);

    logic        ms_valid;
    logic [74:0] bus_r;
    logic        dok_seen;
    logic [31:0] rdata_buf;

    logic        req_issued;
    logic        res_from_mem;
    logic [2:0]  ld_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign {req_issued, res_from_mem, ld_op, gr_we, dest, alu_result, pc} = bus_r;

    logic        ms_ready_go;
    logic        es_accept;
    logic        ms_leave;
    logic        dok_capture;
    logic        data_pending;
    logic [31:0] eff_rdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;
    logic [31:0] final_result;

    assign ms_ready_go        = ~req_issued | dok_seen | bus.data_sram_data_ok;
    assign bus.ms_allowin     = ~ms_valid | (ms_ready_go & bus.ws_allowin);
    assign bus.ms_to_ws_valid = ms_valid & ms_ready_go;

    assign es_accept = bus.es_to_ms_valid & bus.ms_allowin;
    assign ms_leave  = bus.ms_to_ws_valid & bus.ws_allowin;

    // A response that writeback cannot take yet is parked until it can.
    // Stray data_ok with no memory instruction held is ignored.
    assign dok_capture = ms_valid & req_issued & ~dok_seen
                       & bus.data_sram_data_ok & ~bus.ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid  <= 1'b0;
            bus_r     <= '0;
            dok_seen  <= 1'b0;
            rdata_buf <= '0;
        end else begin
            if (bus.ms_allowin) begin
                ms_valid <= bus.es_to_ms_valid;
            end
            if (es_accept) begin
                bus_r    <= bus.es_to_ms_bus;
                dok_seen <= 1'b0;
            end else if (ms_leave) begin
                dok_seen <= 1'b0;
            end else if (dok_capture) begin
                dok_seen <= 1'b1;
            end
            if (dok_capture) begin
                rdata_buf <= bus.data_sram_rdata;
            end
        end
    end

    assign eff_rdata = dok_seen ? rdata_buf : bus.data_sram_rdata;

    always_comb begin
        ld_byte = eff_rdata[7:0];
        case (alu_result[1:0])
            2'd0: ld_byte = eff_rdata[7:0];
            2'd1: ld_byte = eff_rdata[15:8];
            2'd2: ld_byte = eff_rdata[23:16];
            2'd3: ld_byte = eff_rdata[31:24];
            default: ld_byte = eff_rdata[7:0];
        endcase
        ld_half = alu_result[1] ? eff_rdata[31:16] : eff_rdata[15:0];
    end

    always_comb begin
        ld_result = eff_rdata;
        case (ld_op)
            3'b001:  ld_result = {{24{ld_byte[7]}}, ld_byte};
            3'b011:  ld_result = {24'd0, ld_byte};
            3'b010:  ld_result = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_result = {16'd0, ld_half};
            default: ld_result = eff_rdata;
        endcase
    end

    assign final_result = res_from_mem ? ld_result : alu_result;
    assign data_pending = ms_valid & res_from_mem & ~ms_ready_go;

    assign bus.ms_to_ws_bus = {gr_we, dest, final_result, pc};
    assign bus.ms_to_ds_fwd = {ms_valid, gr_we, dest, data_pending, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: drives execute, SRAM and writeback sides and
// compares against a transaction-level model of the stage.
module tb_mem_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_if m();

    mem_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m)
    );

    typedef struct {
        logic [74:0] bus;
        logic [31:0] rdata;
        int          delay;
    } instr_t;

    instr_t      stim_q[$];
    logic        ws_pat[$];
    int          ws_prob     = 100;
    int          bubble_prob = 0;

    bit          occ = 1'b0;
    bit          delivered;
    int          waited;
    instr_t      cur;
    logic [69:0] cur_exp;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [74:0] got, input logic [74:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [69:0] expect_of(input instr_t t);
        logic [31:0] alu, w, b, h, res;
        int          off;
        alu = t.bus[63:32];
        w   = t.rdata;
        off = int'(alu[1:0]);
        b   = (w >> (8 * off)) & 32'h0000_00ff;
        h   = (w >> (16 * (off / 2))) & 32'h0000_ffff;
        if (!t.bus[73]) begin
            res = alu;
        end else begin
            case (t.bus[72:70])
                3'b001:  res = (b >= 32'd128)   ? (b | 32'hffff_ff00) : b;
                3'b011:  res = b;
                3'b010:  res = (h >= 32'd32768) ? (h | 32'hffff_0000) : h;
                3'b100:  res = h;
                default: res = w;
            endcase
        end
        return {t.bus[69], t.bus[68:64], res, t.bus[31:0]};
    endfunction

    // kind: 0 = alu op, 1 = load, 2 = store
    function automatic instr_t make_instr(input int kind, input logic [2:0] op, input logic gw,
                                          input logic [4:0] dst, input logic [31:0] alu,
                                          input logic [31:0] pc, input logic [31:0] rd, input int dly);
        instr_t t;
        t.bus   = {(kind != 0), (kind == 1), op, gw, dst, alu, pc};
        t.rdata = rd;
        t.delay = dly;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        return make_instr(int'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
                          int'($urandom_range(0, 4)));
    endfunction

    // One clock cycle: drive after the edge, compare at negedge, advance model at posedge.
    task automatic step();
        instr_t      nx;
        bit          have, ws, dok, ready, exp_valid, exp_allow, exp_pend;
        logic [95:0] junk;
        have = (stim_q.size() > 0) && (int'($urandom_range(0, 99)) >= bubble_prob);
        if (have) nx = stim_q[0];
        junk = {$urandom, $urandom, $urandom};
        m.es_to_ms_valid = have;
        m.es_to_ms_bus   = have ? nx.bus : junk[74:0];
        if (ws_pat.size() > 0) ws = ws_pat.pop_front();
        else                   ws = int'($urandom_range(0, 99)) < ws_prob;
        m.ws_allowin = ws;
        dok = occ && cur.bus[74] && !delivered && (waited >= cur.delay);
        m.data_sram_data_ok = dok;
        m.data_sram_rdata   = dok ? cur.rdata : $urandom;

        @(negedge clk);
        ready     = !cur.bus[74] || delivered || dok;
        exp_valid = occ && ready;
        exp_allow = !occ || (ready && ws);
        exp_pend  = occ && cur.bus[73] && !ready;
        check_val("allowin",  75'(m.ms_allowin),       75'(exp_allow));
        check_val("ws_valid", 75'(m.ms_to_ws_valid),   75'(exp_valid));
        check_val("fwd_valid", 75'(m.ms_to_ds_fwd[39]), 75'(occ));
        check_val("fwd_pending", 75'(m.ms_to_ds_fwd[32]), 75'(exp_pend));
        if (occ) begin
            check_val("fwd_dest", 75'(m.ms_to_ds_fwd[38:33]), 75'(cur_exp[69:64]));
        end
        if (exp_valid) begin
            check_val("ws_bus",     75'(m.ms_to_ws_bus),       75'(cur_exp));
            check_val("fwd_result", 75'(m.ms_to_ds_fwd[31:0]), 75'(cur_exp[63:32]));
        end

        @(posedge clk);
        if (exp_valid && ws) begin
            occ = 1'b0;
        end else if (occ) begin
            if (dok) delivered = 1'b1;
            waited++;
        end
        if (have && exp_allow) begin
            void'(stim_q.pop_front());
            occ       = 1'b1;
            cur       = nx;
            cur_exp   = expect_of(nx);
            waited    = 0;
            delivered = 1'b0;
        end
        #1;
    endtask

    task automatic run_until_idle(input int max_cycles);
        int c = 0;
        while ((stim_q.size() > 0 || occ) && c < max_cycles) begin
            step();
            c++;
        end
        if (stim_q.size() > 0 || occ) begin
            check_val("drain_timeout", 75'(c), 75'(max_cycles + 1));
            stim_q.delete();
            occ = 1'b0;
        end
        step();
    endtask

    task automatic do_reset();
        reset               = 1'b1;
        m.es_to_ms_valid    = 1'b0;
        m.es_to_ms_bus      = '0;
        m.data_sram_data_ok = 1'b0;
        m.data_sram_rdata   = '0;
        m.ws_allowin        = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_allowin", 75'(m.ms_allowin),     75'(1));
        check_val("rst_valid",   75'(m.ms_to_ws_valid), 75'(0));
        check_val("rst_ws_bus",  75'(m.ms_to_ws_bus),   75'(0));
        check_val("rst_fwd",     75'(m.ms_to_ds_fwd),   75'(0));
        occ = 1'b0;
        ws_pat.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();

        // alu op, single-cycle pass-through
        ws_prob = 100;
        stim_q.push_back(make_instr(0, 3'b000, 1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000, 32'h0, 0));
        run_until_idle(20);

        // ld.b offset 3, data_ok in the second cycle in the stage
        stim_q.push_back(make_instr(1, 3'b001, 1'b1, 5'd7, 32'h0000_1003, 32'h1c00_0004, 32'h80ff_0000, 1));
        run_until_idle(20);

        // ld.hu / ld.h offset 2
        stim_q.push_back(make_instr(1, 3'b100, 1'b1, 5'd8, 32'h0000_2002, 32'h1c00_0008, 32'hbeef_1234, 0));
        stim_q.push_back(make_instr(1, 3'b010, 1'b1, 5'd9, 32'h0000_2002, 32'h1c00_000c, 32'hbeef_1234, 0));
        run_until_idle(20);

        // response buffered while writeback stalls for three cycles
        stim_q.push_back(make_instr(1, 3'b000, 1'b1, 5'd10, 32'h0000_3000, 32'h1c00_0010, 32'hcafe_f00d, 0));
        ws_pat = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        run_until_idle(20);

        // store then back-to-back alu op
        stim_q.push_back(make_instr(2, 3'b000, 1'b0, 5'd0, 32'h0000_4000, 32'h1c00_0014, 32'h0, 2));
        stim_q.push_back(make_instr(0, 3'b000, 1'b1, 5'd11, 32'h0bad_cafe, 32'h1c00_0018, 32'h0, 0));
        run_until_idle(20);

        // randomized traffic, busy and stalling writeback
        ws_prob     = 70;
        bubble_prob = 25;
        for (int i = 0; i < 300; i++) stim_q.push_back(rand_instr());
        run_until_idle(5000);
        ws_prob     = 20;
        bubble_prob = 0;
        for (int i = 0; i < 150; i++) stim_q.push_back(rand_instr());
        run_until_idle(5000);

        // reset while a load waits for its response
        ws_prob = 100;
        stim_q.push_back(make_instr(1, 3'b000, 1'b1, 5'd12, 32'h0000_5000, 32'h1c00_001c, 32'h1111_2222, 50));
        step();
        step();
        do_reset();

        ws_prob = 60;
        for (int i = 0; i < 50; i++) stim_q.push_back(rand_instr());
        run_until_idle(2000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
